// File: rtl/wide_and_sequencer_if.sv
// rtl/wide_and_sequencer_if.sv - operand/result handshake bundle for the wide AND sequencer
interface wide_and_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, f
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, f
    );
endinterface

// File: rtl/wide_and_sequencer.sv
// rtl/wide_and_sequencer.sv - WIDTH-bit AND computed through one shared AND8 slice, LSB lane first
module and8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] z
);
    assign z = x & y;
endmodule

module wide_and_sequencer #(
    parameter int  WIDTH = 32,
    localparam int NSL   = WIDTH / 8,
    localparam int SW    = (NSL > 1) ? $clog2(NSL) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_and_sequencer_if.slave  bus,
    output logic                 busy,
    output logic [SW-1:0]        slice
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] f_r;
    logic [7:0]       lane_a;
    logic [7:0]       lane_b;
    logic [7:0]       lane_f;
    logic             accept;
    logic             handoff;
    logic             last_slice;

    assign accept     = bus.in_valid && (state == IDLE);
    assign handoff    = bus.out_ready && (state == DONE);
    assign last_slice = (slice == SW'(NSL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_slice) state_nx = DONE;
            DONE:    if (handoff) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        busy          = (state == RUN) || (state == DONE);
    end

    // Lane select uses a compare per lane so non-power-of-two NSL never indexes past the operands.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < NSL; i++) begin
            if (slice == SW'(i)) begin
                lane_a = a_r[8*i +: 8];
                lane_b = b_r[8*i +: 8];
            end
        end
    end

    and8 u_and8 (
        .x (lane_a),
        .y (lane_b),
        .z (lane_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            f_r   <= '0;
            slice <= '0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            f_r   <= '0;
            slice <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NSL; i++) begin
                if (slice == SW'(i)) begin
                    f_r[8*i +: 8] <= lane_f;
                end
            end
            slice <= last_slice ? '0 : slice + 1'b1;
        end
    end

    assign bus.f = f_r;
endmodule

// File: tb/tb_wide_and_sequencer.sv
// tb/tb_wide_and_sequencer.sv - directed vector bench for wide_and_sequencer (WIDTH=32 and WIDTH=8)
module tb_wide_and_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy32;
    logic [1:0] slice32;
    logic       busy8;
    logic [0:0] slice8;

    int n_cmp  = 0;
    int n_fail = 0;

    wide_and_sequencer_if #(.WIDTH(32)) bus32 ();
    wide_and_sequencer_if #(.WIDTH(8))  bus8 ();

    wide_and_sequencer #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus32),
        .busy  (busy32),
        .slice (slice32)
    );

    wide_and_sequencer #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus8),
        .busy  (busy8),
        .slice (slice8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready before accept", 32'(bus32.in_ready), 32'd1);
        bus32.in_valid = 1'b1;
        bus32.a        = a;
        bus32.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.a        = 32'h0;
        bus32.b        = 32'h0;
    endtask

    // Entered at the first negedge after the accept edge; returns edges elapsed until out_valid.
    task automatic wait_done32(input logic [31:0] exp, output int n);
        logic [31:0] mask;
        n = 0;
        while (!bus32.out_valid && n < 20) begin
            if (n < 4) begin
                mask = (n == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - 8 * n));
                check("slice in run", 32'(slice32), 32'(n));
                check("partial f", bus32.f, exp & mask);
                check("busy in run", 32'(busy32), 32'd1);
            end
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[7];
    int   n;
    int   seen;

    initial begin
        vecs[0] = '{32'hFFFF_0F0F, 32'h0101_FFFF, 32'h0101_0F0F};
        vecs[1] = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        vecs[2] = '{32'h1234_5678, 32'hF0F0_F0F0, 32'h1030_5070};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0E0D_0E0F};
        vecs[6] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};

        bus32.in_valid  = 1'b0;
        bus32.a         = 32'h0;
        bus32.b         = 32'h0;
        bus32.out_ready = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.a          = 8'h0;
        bus8.b          = 8'h0;
        bus8.out_ready  = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("reset f", bus32.f, 32'h0);
        check("reset out_valid", 32'(bus32.out_valid), 32'd0);
        check("reset in_ready", 32'(bus32.in_ready), 32'd1);
        check("reset busy", 32'(busy32), 32'd0);
        check("reset slice", 32'(slice32), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start32(vecs[i].a, vecs[i].b);
            bus32.out_ready = (i % 2 == 1);
            wait_done32(vecs[i].f, n);
            check("latency", 32'(n), 32'd4);
            check("result f", bus32.f, vecs[i].f);
            check("slice in done", 32'(slice32), 32'd0);
            check("in_ready in done", 32'(bus32.in_ready), 32'd0);
            bus32.out_ready = 1'b1;
            @(negedge clk);
            bus32.out_ready = 1'b0;
            check("out_valid after handoff", 32'(bus32.out_valid), 32'd0);
            check("in_ready after handoff", 32'(bus32.in_ready), 32'd1);
            check("busy after handoff", 32'(busy32), 32'd0);
        end

        // Held result under back-pressure with a competing operand request.
        start32(32'h1234_5678, 32'hFFFF_0000);
        wait_done32(32'h1234_0000, n);
        check("hold latency", 32'(n), 32'd4);
        bus32.in_valid = 1'b1;
        bus32.a        = 32'hFFFF_FFFF;
        bus32.b        = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold f", bus32.f, 32'h1234_0000);
            check("hold out_valid", 32'(bus32.out_valid), 32'd1);
            check("hold in_ready", 32'(bus32.in_ready), 32'd0);
        end
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
        check("simul handoff out_valid", 32'(bus32.out_valid), 32'd0);
        check("simul handoff busy", 32'(busy32), 32'd0);
        check("simul handoff in_ready", 32'(bus32.in_ready), 32'd1);

        // Asynchronous reset asserted mid-cycle while a result is held.
        start32(32'hFFFF_FFFF, 32'h0F0F_0F0F);
        wait_done32(32'h0F0F_0F0F, n);
        check("pre-reset f", bus32.f, 32'h0F0F_0F0F);
        #2 rst = 1'b1;
        #1;
        check("async reset f", bus32.f, 32'h0);
        check("async reset out_valid", 32'(bus32.out_valid), 32'd0);
        check("async reset in_ready", 32'(bus32.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulse mid-RUN at slice 2.
        start32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 0; c < 6 && slice32 != 2'd2; c++) @(negedge clk);
        check("reached slice 2", 32'(slice32), 32'd2);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("run reset f", bus32.f, 32'h0);
        check("run reset busy", 32'(busy32), 32'd0);
        check("run reset slice", 32'(slice32), 32'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus32.out_valid) seen++;
        end
        check("no out_valid after abort", 32'(seen), 32'd0);

        // WIDTH=8: single-edge RUN.
        @(negedge clk);
        check("w8 in_ready", 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b1;
        bus8.a        = 8'b0101_1001;
        bus8.b        = 8'b1011_1110;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 8'h0;
        check("w8 run busy", 32'(busy8), 32'd1);
        check("w8 run slice", 32'(slice8), 32'd0);
        check("w8 run out_valid", 32'(bus8.out_valid), 32'd0);
        @(negedge clk);
        check("w8 out_valid", 32'(bus8.out_valid), 32'd1);
        check("w8 f", 32'(bus8.f), 32'h18);
        check("w8 done slice", 32'(slice8), 32'd0);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check("w8 in_ready after", 32'(bus8.in_ready), 32'd1);
        check("w8 out_valid after", 32'(bus8.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
